// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver:
//                the frame state encoding and the default oversampling rate.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Default number of baud ticks per bit period
    localparam int c_default_oversample = 16;

    // Frame-level states, common to both directions
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to RESET_VAL so an idle-high line does
//                not produce a false edge when reset releases.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Validates the start bit at its
//                centre, samples each data bit at its centre (LSB first) and
//                delivers the word with a one-clock rx_done strobe and a
//                stop-bit framing-error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = c_default_oversample,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    localparam int c_s_w = $clog2(OVERSAMPLE * STOP_BITS);
    localparam int c_n_w = $clog2(DBIT);

    // Tick counts at which each state makes its decision
    localparam logic [c_s_w-1:0] c_start_mid = c_s_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_s_w-1:0] c_bit_last  = c_s_w'(OVERSAMPLE - 1);
    localparam logic [c_s_w-1:0] c_stop_last = c_s_w'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [c_n_w-1:0] c_n_last    = c_n_w'(DBIT - 1);

    logic             w_rx_s;

    uart_state_t      r_state,     w_state_nx;
    logic [c_s_w-1:0] r_s_cnt,     w_s_cnt_nx;
    logic [c_n_w-1:0] r_n_cnt,     w_n_cnt_nx;
    logic [DBIT-1:0]  r_shift,     w_shift_nx;
    logic [DBIT-1:0]  r_rx_data,   w_rx_data_nx;
    logic             r_rx_done,   w_rx_done_nx;
    logic             r_frame_err, w_frame_err_nx;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // State, counters, shift register and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s_cnt     <= '0;
            r_n_cnt     <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_s_cnt     <= w_s_cnt_nx;
            r_n_cnt     <= w_n_cnt_nx;
            r_shift     <= w_shift_nx;
            r_rx_data   <= w_rx_data_nx;
            r_rx_done   <= w_rx_done_nx;
            r_frame_err <= w_frame_err_nx;
        end
    end

    // Next-state logic; only IDLE reacts on non-tick cycles
    always_comb begin
        w_state_nx     = r_state;
        w_s_cnt_nx     = r_s_cnt;
        w_n_cnt_nx     = r_n_cnt;
        w_shift_nx     = r_shift;
        w_rx_data_nx   = r_rx_data;
        w_rx_done_nx   = 1'b0;
        w_frame_err_nx = r_frame_err;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nx = START;
                    w_s_cnt_nx = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (r_s_cnt == c_start_mid) begin
                        w_s_cnt_nx = '0;
                        if (!w_rx_s) begin
                            w_state_nx = DATA;
                            w_n_cnt_nx = '0;
                        end else begin
                            // Line went back high before mid-bit: glitch
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_s_cnt_nx = r_s_cnt + c_s_w'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (r_s_cnt == c_bit_last) begin
                        w_s_cnt_nx = '0;
                        w_shift_nx = {w_rx_s, r_shift[DBIT-1:1]};
                        if (r_n_cnt == c_n_last) begin
                            w_state_nx = STOP;
                        end else begin
                            w_n_cnt_nx = r_n_cnt + c_n_w'(1);
                        end
                    end else begin
                        w_s_cnt_nx = r_s_cnt + c_s_w'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (r_s_cnt == c_stop_last) begin
                        // Leave at the stop-bit centre so a back-to-back
                        // start edge is caught immediately
                        w_state_nx     = IDLE;
                        w_s_cnt_nx     = '0;
                        w_rx_data_nx   = r_shift;
                        w_frame_err_nx = ~w_rx_s;
                        w_rx_done_nx   = 1'b1;
                    end else begin
                        w_s_cnt_nx = r_s_cnt + c_s_w'(1);
                    end
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_s_cnt_nx = '0;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. s_tick fires every
//                4 clocks, so one bit period is 64 clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit_clks = 64;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Records of every rx_done pulse seen by the monitor
    logic [7:0] q_data[$];
    logic       q_err[$];
    int         q_cyc[$];
    logic       q_busy[$];
    logic       q_pbusy[$];
    logic       prev_busy = 1'b0;

    uart_rx #(
        .DBIT       (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tick    (s_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-clock tick every fourth clock
    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_tick = (cyc % 4 == 0);
        end
    end

    // Capture each completed frame on the falling edge
    always @(negedge clk) begin
        if (rx_done) begin
            q_data.push_back(rx_data);
            q_err.push_back(frame_err);
            q_cyc.push_back(cyc);
            q_busy.push_back(busy);
            q_pbusy.push_back(prev_busy);
        end
        prev_busy = busy;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_err.delete();
        q_cyc.delete();
        q_busy.delete();
        q_pbusy.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(c_bit_clks);
    endtask

    // Stop bit driven low covers its centre, then the line is released
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            wait_clks(48);
            rx = 1'b1;
            wait_clks(16);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        checks++;
        if (rx_data !== 8'h00 || frame_err !== 1'b0 || rx_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: data=%h err=%b done=%b busy=%b expected 00/0/0/0",
                     rx_data, frame_err, rx_done, busy);
        end
        rst_n = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_single();
        clear_q();
        send_frame(8'h55, 1'b1);
        wait_clks(20);
        checks++;
        if (q_data.size() != 1) begin
            failures++;
            $display("FAIL single_count: got %0d pulses expected 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'h55 || q_err[0] !== 1'b0) begin
                failures++;
                $display("FAIL single_data: data=%h err=%b expected 55/0", q_data[0], q_err[0]);
            end
            checks++;
            if (q_busy[0] !== 1'b0 || q_pbusy[0] !== 1'b1) begin
                failures++;
                $display("FAIL single_busy: busy_at_done=%b busy_before=%b expected 0/1",
                         q_busy[0], q_pbusy[0]);
            end
        end
        checks++;
        if (rx_data !== 8'h55 || rx_done !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: data=%h done=%b expected 55/0", rx_data, rx_done);
        end
    endtask

    task automatic test_two_frames();
        clear_q();
        send_frame(8'hAB, 1'b1);
        wait_clks(100);
        send_frame(8'h00, 1'b1);
        wait_clks(20);
        checks++;
        if (q_data.size() != 2) begin
            failures++;
            $display("FAIL two_count: got %0d pulses expected 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'hAB || q_data[1] !== 8'h00 || q_err[0] !== 1'b0 || q_err[1] !== 1'b0) begin
                failures++;
                $display("FAIL two_data: got %h/%b %h/%b expected ab/0 00/0",
                         q_data[0], q_err[0], q_data[1], q_err[1]);
            end
        end
    endtask

    task automatic test_frame_err();
        clear_q();
        send_frame(8'hA5, 1'b0);
        wait_clks(100);
        checks++;
        if (q_data.size() != 1) begin
            failures++;
            $display("FAIL ferr_count: got %0d pulses expected 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'hA5 || q_err[0] !== 1'b1) begin
                failures++;
                $display("FAIL ferr_data: data=%h err=%b expected a5/1", q_data[0], q_err[0]);
            end
        end
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_hold: err=%b busy=%b expected 1/0", frame_err, busy);
        end
        clear_q();
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        checks++;
        if (q_data.size() != 1) begin
            failures++;
            $display("FAIL ferr_clear_count: got %0d pulses expected 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'h3C || q_err[0] !== 1'b0) begin
                failures++;
                $display("FAIL ferr_clear: data=%h err=%b expected 3c/0", q_data[0], q_err[0]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_q();
        rx = 1'b0;
        wait_clks(8);
        rx = 1'b1;
        wait_clks(8);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_start: busy=%b expected 1", busy);
        end
        wait_clks(100);
        checks++;
        if (q_data.size() != 0 || busy !== 1'b0 || rx_data !== 8'h3C || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: pulses=%0d busy=%b data=%h err=%b expected 0/0/3c/0",
                     q_data.size(), busy, rx_data, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_clks(20);
        checks++;
        if (q_data.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d pulses expected 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'hFF || q_data[1] !== 8'h81 || q_err[0] !== 1'b0 || q_err[1] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_data: got %h/%b %h/%b expected ff/0 81/0",
                         q_data[0], q_err[0], q_data[1], q_err[1]);
            end
            checks++;
            if (q_cyc[1] - q_cyc[0] != 640) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d clks expected 640", q_cyc[1] - q_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        d = 8'hC3;
        clear_q();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        wait_clks(24);
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        rx    = 1'b1;
        wait_clks(700);
        checks++;
        if (q_data.size() != 0 || rx_data !== 8'h00 || frame_err !== 1'b0 || busy !== 1'b0 || rx_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: pulses=%0d data=%h err=%b busy=%b done=%b expected 0/00/0/0/0",
                     q_data.size(), rx_data, frame_err, busy, rx_done);
        end
        send_frame(8'h5A, 1'b1);
        wait_clks(20);
        checks++;
        if (q_data.size() != 1) begin
            failures++;
            $display("FAIL abort_next_count: got %0d pulses expected 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 8'h5A || q_err[0] !== 1'b0) begin
                failures++;
                $display("FAIL abort_next_data: data=%h err=%b expected 5a/0", q_data[0], q_err[0]);
            end
        end
    endtask

    initial begin
        wait_clks(1);
        test_reset();
        test_single();
        test_two_frames();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
